// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types for the instruction/data memory arbiter.
//
// Contents:
//   host_t      : host identifier stored in the read-route FIFO (0=instr, 1=data)
//   arb_state_t : arbiter FSM states (IDLE picks a winner, HOLD keeps it while
//                 the memory agent stalls)
//   pick_winner : arbitration helper used by the top level
//
// Configuration macro referenced by users of this package: ARB_ROUND_ROBIN_EN
// (selected in mem_arbiter.sv; the helper here just takes a priority input).
package mem_arbiter_pkg;

  typedef enum logic {
    HOST_INSTR = 1'b0,
    HOST_DATA  = 1'b1
  } host_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Returns the host to grant. Data wins a tie unless prefer_instr is set.
  // Only meaningful when at least one request is present.
  function automatic host_t pick_winner(input logic instr_req,
                                        input logic data_req,
                                        input logic prefer_instr);
    if (instr_req && (!data_req || prefer_instr)) begin
      return HOST_INSTR;
    end
    return HOST_DATA;
  endfunction

endpackage

// File: rtl/mem_arb_route_fifo.sv
// mem_arb_route_fifo -- small FIFO remembering which host issued each
// accepted-but-unanswered read, so returning read data can be steered.
//
// Parameters:
//   WIDTH : entry width (1 for a host id)
//   DEPTH : number of entries, power of two
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : entry to store
//   pop        : discard the head entry (ignored when empty)
//   head       : current head entry (combinational, valid when !empty)
//   count      : number of stored entries, 0..DEPTH
//   empty      : count == 0
module mem_arb_route_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign push_ok = push && (count_reg != CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset: stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- Avalon-MM pipelined-read arbiter sharing one memory agent
// between an instruction-fetch host and a data host.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : under contention the last-granted host loses the next tie
//   undefined : the data host always wins a tie
//
// Parameters: ADDR_W (address width), DATA_W (data width, byteenable is
// DATA_W/8), MAX_PENDING (outstanding reads, power of two 2..16).
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   i_*                   : instruction host (read only)
//   d_*                   : data host (read/write)
//   m_*                   : memory agent
//   err_orphan            : sticky, read data returned with nothing pending
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction host
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  // data host
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  // memory agent
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  // status
  output logic                err_orphan
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  arb_state_t       state_reg;
  host_t            grant_reg;
  logic             ready_reg;       // low until the first clock after reset
  logic             err_orphan_reg;

  logic             full;
  logic             instr_req;
  logic             data_req;
  logic             prefer_instr;
  logic             granted;
  host_t            winner;

  logic             fifo_push;
  logic             fifo_pop;
  logic [0:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             head_is_data;

  // A full route FIFO blocks new reads even if a pop happens this cycle;
  // writes are unaffected. A write with d_read also high is a write.
  assign full      = (fifo_count == CNT_W'(MAX_PENDING));
  assign instr_req = i_read && !full;
  assign data_req  = d_write || (d_read && !full);

`ifdef ARB_ROUND_ROBIN_EN
  host_t rr_last_reg;
  assign prefer_instr = (rr_last_reg == HOST_DATA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_reg <= HOST_INSTR;
    end else if (granted && !m_waitrequest) begin
      rr_last_reg <= winner;
    end
  end
`else
  assign prefer_instr = 1'b0;
`endif

  // Winner selection: fresh in IDLE, frozen while the agent stalls in HOLD.
  always_comb begin
    winner  = HOST_INSTR;
    granted = 1'b0;
    if (state_reg == ST_HOLD) begin
      winner  = grant_reg;
      granted = ready_reg;
    end else begin
      winner  = pick_winner(instr_req, data_req, prefer_instr);
      granted = ready_reg && (instr_req || data_req);
    end
  end

  // Command mux onto the memory agent; all-zero when nothing is granted.
  always_comb begin
    m_address    = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = '0;
    m_byteenable = '0;
    if (granted) begin
      if (winner == HOST_DATA) begin
        m_address    = d_address;
        m_write      = d_write;
        m_read       = !d_write;
        m_writedata  = d_write ? d_writedata : '0;
        m_byteenable = d_byteenable;
      end else begin
        m_address    = i_address;
        m_read       = 1'b1;
        m_byteenable = '1;
      end
    end
  end

  // Only the granted host can see waitrequest low, and only when the agent
  // accepts; this also holds both hosts off during and right after reset.
  assign i_waitrequest = !(granted && (winner == HOST_INSTR) && !m_waitrequest);
  assign d_waitrequest = !(granted && (winner == HOST_DATA)  && !m_waitrequest);

  assign fifo_push = m_read && !m_waitrequest;
  assign fifo_pop  = m_readdatavalid && !fifo_empty;

  mem_arb_route_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_PENDING)
  ) u_route_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (winner),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Returning data is steered to the host recorded at the FIFO head.
  assign head_is_data    = (host_t'(fifo_head) == HOST_DATA);
  assign i_readdatavalid = fifo_pop && !head_is_data;
  assign d_readdatavalid = fifo_pop && head_is_data;
  assign i_readdata      = m_readdata;
  assign d_readdata      = m_readdata;
  assign err_orphan      = err_orphan_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= HOST_INSTR;
      ready_reg      <= 1'b0;
      err_orphan_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (m_readdatavalid && fifo_empty) begin
        err_orphan_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (granted && m_waitrequest) begin
            state_reg <= ST_HOLD;
            grant_reg <= winner;
          end
        end
        ST_HOLD: begin
          if (!m_waitrequest) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter. Expected memory
// commands and read responses are queued when stimulus is driven and
// compared when the arbiter issues them. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = 4'hF;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic        err_orphan;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PENDING(4)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic        host;   // 0=instr, 1=data
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;

  int   i_left = 0;
  int   d_left = 0;
  logic i_acc = 1'b0;
  logic d_acc = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if ((m_read || m_write) && !m_waitrequest) begin
        if (cmd_q.size() == 0) begin
          check("unexp_cmd", {m_read, m_write}, 2'b00);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          check("cmd_kind", {m_write, m_read}, {e.we, !e.we});
          check("cmd_addr", m_address, e.addr);
          if (e.we) begin
            check("cmd_wdata", m_writedata, e.wdata);
            check("cmd_be", m_byteenable, e.be);
          end
          $display("cmd   we=%0b addr=%08h wdata=%08h", m_write, m_address, m_writedata);
        end
      end
      if (i_readdatavalid || d_readdatavalid) begin
        if (rsp_q.size() == 0) begin
          check("unexp_rsp", {i_readdatavalid, d_readdatavalid}, 2'b00);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_route", {d_readdatavalid, i_readdatavalid}, r.host ? 2'b10 : 2'b01);
          check("rsp_data", r.host ? d_readdata : i_readdata, r.data);
          $display("rsp   host=%0d data=%08h", r.host, r.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.be = be;
    cmd_q.push_back(c);
  endtask

  // One cycle: sample acceptance mid-cycle, then retire accepted requests.
  task automatic tick();
    @(negedge clk);
    i_acc = i_read && !i_waitrequest;
    d_acc = (d_read || d_write) && !d_waitrequest;
    @(posedge clk);
    #1;
    if (i_acc) begin
      i_left--;
      i_address += 32'd4;
      if (i_left == 0) i_read = 1'b0;
    end
    if (d_acc) begin
      d_left--;
      d_address += 32'd4;
      if (d_left == 0) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
  endtask

  task automatic run_until_idle(input string tag);
    for (int n = 0; n < 30 && (i_read || d_read || d_write); n++) tick();
    if (i_read || d_read || d_write) begin
      check(tag, {i_read, d_read, d_write}, 3'b000);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_left = 0; d_left = 0;
    end
  endtask

  task automatic respond(input logic host, input logic [31:0] data);
    rsp_t r;
    r.host = host; r.data = data;
    rsp_q.push_back(r);
    m_readdatavalid = 1'b1;
    m_readdata      = data;
    tick();
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
  endtask

  task automatic issue(input logic host, input logic [31:0] addr);
    push_cmd(1'b0, addr, '0, 4'hF);
    if (host) begin
      d_address = addr; d_read = 1'b1; d_left = 1;
    end else begin
      i_address = addr; i_read = 1'b1; i_left = 1;
    end
    run_until_idle("issue_timeout");
  endtask

  initial begin
    logic [3:0] seq;
    logic [3:0] seq_exp;

    // ---- reset state ----
    i_address = 32'h123;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_wait", i_waitrequest, 1'b1);
    check("rst_d_wait", d_waitrequest, 1'b1);
    check("rst_m_cmd", {m_read, m_write}, 2'b00);
    check("rst_orphan", err_orphan, 1'b0);
    check("rst_rdv", {i_readdatavalid, d_readdatavalid}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("idle_m_addr", m_address, 32'h0);
    check("idle_m_cmd", {m_read, m_write}, 2'b00);
    @(posedge clk); #1;

    // ---- contention: data first, instr next cycle ----
    i_address = 32'h100; d_address = 32'h200;
    push_cmd(1'b0, 32'h200, '0, 4'hF);
    push_cmd(1'b0, 32'h100, '0, 4'hF);
    i_left = 1; d_left = 1; i_read = 1'b1; d_read = 1'b1;
    tick();
    check("t1_d_first", {d_acc, i_acc}, 2'b10);
    tick();
    check("t1_i_next", {d_acc, i_acc}, 2'b01);
    respond(1'b1, 32'hAAAA);
    respond(1'b0, 32'hBBBB);

    // ---- sustained contention: two reads per host ----
    i_address = 32'h100; d_address = 32'h200;
`ifdef ARB_ROUND_ROBIN_EN
    push_cmd(1'b0, 32'h200, '0, 4'hF); push_cmd(1'b0, 32'h100, '0, 4'hF);
    push_cmd(1'b0, 32'h204, '0, 4'hF); push_cmd(1'b0, 32'h104, '0, 4'hF);
    seq_exp = 4'b1010;
`else
    push_cmd(1'b0, 32'h200, '0, 4'hF); push_cmd(1'b0, 32'h204, '0, 4'hF);
    push_cmd(1'b0, 32'h100, '0, 4'hF); push_cmd(1'b0, 32'h104, '0, 4'hF);
    seq_exp = 4'b1100;
`endif
    seq = '0;
    i_left = 2; d_left = 2; i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      seq = {seq[2:0], d_acc};
    end
    check("t2_grant_seq", seq, seq_exp);
    run_until_idle("t2_timeout");
    for (int k = 0; k < 4; k++) respond(seq_exp[3-k], 32'h10 + k);

    // ---- stalled write: command stable, instr held off ----
    push_cmd(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
    push_cmd(1'b0, 32'h100, '0, 4'hF);
    d_address = 32'h40; d_writedata = 32'hDEADBEEF; d_write = 1'b1; d_left = 1;
    i_address = 32'h100; i_read = 1'b1; i_left = 1;
    m_waitrequest = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t3_m_write", {m_write, m_read}, 2'b10);
      check("t3_m_addr", m_address, 32'h40);
      check("t3_m_wdata", m_writedata, 32'hDEADBEEF);
      check("t3_i_wait", i_waitrequest, 1'b1);
      check("t3_d_wait", d_waitrequest, (c < 3));
      @(posedge clk); #1;
      if (c == 2) m_waitrequest = 1'b0;
    end
    d_write = 1'b0; d_left = 0;
    run_until_idle("t3_timeout");
    respond(1'b0, 32'h55);

    // ---- FIFO full: fifth instr read held until a pop ----
    i_address = 32'h300;
    for (int k = 0; k < 5; k++) push_cmd(1'b0, 32'h300 + 4 * k, '0, 4'hF);
    i_left = 5; i_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_acc", i_acc, 1'b1);
    end
    tick();
    check("t4_held", i_acc, 1'b0);
    begin
      rsp_t r;
      r.host = 1'b0; r.data = 32'h13;
      rsp_q.push_back(r);
    end
    m_readdatavalid = 1'b1; m_readdata = 32'h13;
    @(negedge clk);
    check("t4_full_pop_wait", {i_waitrequest, m_read}, 2'b10);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0; m_readdata = '0;
    tick();
    check("t4_accept_next", i_acc, 1'b1);
    for (int k = 0; k < 4; k++) respond(1'b0, 32'h14 + k);

    // ---- interleaved I,D,I answered in order ----
    issue(1'b0, 32'h500);
    issue(1'b1, 32'h600);
    issue(1'b0, 32'h504);
    respond(1'b0, 32'h1);
    respond(1'b1, 32'h2);
    respond(1'b0, 32'h3);

    // ---- reset mid-HOLD with two reads pending ----
    issue(1'b0, 32'h700);
    issue(1'b0, 32'h704);
    d_address = 32'h800; d_read = 1'b1; d_left = 1;
    m_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_hold_read", {m_read, d_waitrequest}, 2'b11);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_m_cmd", {m_read, m_write}, 2'b00);
    check("t6_rst_wait", {i_waitrequest, d_waitrequest}, 2'b11);
    check("t6_rst_orphan", err_orphan, 1'b0);
    @(posedge clk); #1;
    d_read = 1'b0; d_left = 0; m_waitrequest = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick(); tick();
    m_readdatavalid = 1'b1; m_readdata = 32'h99;
    @(negedge clk);
    check("t6_no_rdv", {i_readdatavalid, d_readdatavalid}, 2'b00);
    @(posedge clk); #1;
    m_readdatavalid = 1'b0; m_readdata = '0;
    @(negedge clk);
    check("t6_orphan_set", err_orphan, 1'b1);
    @(posedge clk); #1;
    tick(); tick();
    @(negedge clk);
    check("t6_orphan_sticky", err_orphan, 1'b1);

    check("cmd_q_drained", cmd_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_PENDING, default 4, maximum accepted-but-unanswered reads (power of two, 2..16).
REQ-004 SHALL have ports clk in 1 (single clock, all logic on rising edge) and rst in 1 (asynchronous, active-low reset).
REQ-005 SHALL have the instruction host port: i_address in ADDR_W, i_read in 1, i_waitrequest out 1, i_readdata out DATA_W, i_readdatavalid out 1.
REQ-006 SHALL have the data host port: d_address in ADDR_W, d_read in 1, d_write in 1, d_writedata in DATA_W, d_byteenable in DATA_W/8, d_waitrequest out 1, d_readdata out DATA_W, d_readdatavalid out 1.
REQ-007 SHALL have the memory agent port: m_address out ADDR_W, m_read out 1, m_write out 1, m_writedata out DATA_W, m_byteenable out DATA_W/8, m_waitrequest in 1, m_readdata in DATA_W, m_readdatavalid in 1.
REQ-008 SHALL have err_orphan out 1: sticky flag, readdatavalid received with no pending read.

Function
REQ-009 SHALL be an Avalon-MM pipelined-read arbiter sharing one memory agent between the instruction fetch and data hosts.
REQ-010 SHALL run FSM states IDLE and HOLD; IDLE picks a winner combinationally and drives its command onto m_* the same cycle.
REQ-011 SHALL move IDLE->HOLD when the granted command sees m_waitrequest=1, keeping grant and m_* stable until m_waitrequest=0, then HOLD->IDLE.
REQ-012 SHALL assert waitrequest to the losing host, and to the winner whenever m_waitrequest=1.
REQ-013 SHALL treat d_read and d_write both high as a write; i_read with d_write pending uses the same arbitration.
REQ-014 SHALL push the grantee id (0=instr, 1=data) into a route FIFO on each accepted read (m_read & !m_waitrequest); writes push nothing.
REQ-015 SHALL route m_readdatavalid/m_readdata combinationally to the host at the FIFO head and pop it the same cycle; the other host's readdatavalid stays 0.
REQ-016 SHALL block new reads (host waitrequest=1, no m_read) while FIFO count == MAX_PENDING, even if a pop occurs that cycle; writes still proceed.
REQ-017 SHALL, on m_readdatavalid with empty FIFO, drop the data and set err_orphan until reset.
REQ-018 SHALL support simultaneous push and pop below full, count unchanged; FIFO pointers wrap modulo MAX_PENDING.
REQ-019 SHALL drive m_read=m_write=0 and m_address/m_writedata/m_byteenable=0 when no host requests.

Reset
REQ-020 SHALL, on rst=0 (async, any state, mid-transaction included), force IDLE, empty FIFO, err_orphan=0, m_read=m_write=0, all readdatavalid=0, round-robin pointer=instr.
REQ-021 SHALL release reset synchronously to clk; host waitrequest outputs SHALL be 1 while in reset.

Configuration
REQ-022 SHALL with ARB_ROUND_ROBIN_EN defined alternate priority under contention, last-granted host losing the next tie; without it data always beats instruction.

Structure
REQ-023 SHALL place the host-id enum (HOST_INSTR, HOST_DATA) and FSM state enum in the shared Types package.
REQ-024 SHALL implement the route FIFO as sub-module mem_arb_route_fifo (width 1, depth MAX_PENDING, count output).

Verification
REQ-025 SHALL test simultaneous i_read@0x100 and d_read@0x200, m_waitrequest=0 -> data granted first, instr next cycle (macro off).
REQ-026 SHALL test same stimulus repeated 4 times with ARB_ROUND_ROBIN_EN -> grants alternate D,I,D,I.
REQ-027 SHALL test d_write 0xDEADBEEF@0x40 with m_waitrequest=1 for 3 cycles -> m_* stable 4 cycles, i_waitrequest=1 throughout.
REQ-028 SHALL test 4 instr reads unanswered -> 5th i_read held off; one m_readdatavalid returns 0x13 on i_readdata, next read accepted the following cycle.
REQ-029 SHALL test interleaved reads I,D,I answered in order with 0x1,0x2,0x3 -> i,d,i readdatavalid with matching data.
REQ-030 SHALL test rst=0 mid-HOLD with 2 pending, then m_readdatavalid -> err_orphan=1, no host readdatavalid.
